wb_port_arbiter: RTL and testbench

- Shares the two register-file write ports between three writeback sources: VLIW ALU slot A, VLIW ALU slot B, and the late-returning load unit L.
- Drives the regWrite1/regWrite2, writeData_1/writeData_2, per-register decode and per-register writeData_sel inputs of the dual-write-data 32-bit register file.
- Resolves same-destination (WAW) conflicts.
- Guards the load unit against starvation by raising a pipeline stall request.

---
 rtl/wb_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: maps ALU slots A/B and the load unit L onto the two
// write ports of the dual-write-data register file, with WAW and starvation handling.
module wb_port_arbiter #(
    parameter int NREG         = 8,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      a_valid,
    input  logic [$clog2(NREG)-1:0]   a_dest,
    input  logic [DW-1:0]             a_data,

    input  logic                      b_valid,
    input  logic [$clog2(NREG)-1:0]   b_dest,
    input  logic [DW-1:0]             b_data,

    input  logic                      ld_valid,
    input  logic [$clog2(NREG)-1:0]   ld_dest,
    input  logic [DW-1:0]             ld_data,
    output logic                      ld_ready,
    output logic                      ld_squash,

    output logic                      regWrite1,
    output logic                      regWrite2,
    output logic [DW-1:0]             writeData_1,
    output logic [DW-1:0]             writeData_2,
    output logic [NREG-1:0]           dec_vec,
    output logic [NREG-1:0]           sel_vec,
    output logic                      stall_req,
    output logic                      err
);

    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic            we1_q, we1_d;
    logic            we2_q, we2_d;
    logic [DW-1:0]   wd1_q, wd1_d;
    logic [DW-1:0]   wd2_q, wd2_d;
    logic [NREG-1:0] dec_q, dec_d;
    logic [NREG-1:0] sel_q, sel_d;
    logic            squash_q, squash_d;
    logic            stall_q, stall_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            a_gnt, b_gnt;
    logic            l_squash, l_gnt, l_p1, l_p2;
    logic [AW-1:0]   dest1, dest2;

    // Grant decisions; during a stall the ALU slots are shut out entirely.
    always_comb begin
        b_gnt    = b_valid && !stall_q;
        a_gnt    = a_valid && !stall_q && !(b_valid && (a_dest == b_dest));
        l_squash = ld_valid && ((a_gnt && (ld_dest == a_dest)) ||
                                (b_gnt && (ld_dest == b_dest)));
        l_gnt    = ld_valid && !l_squash && (!a_gnt || !b_valid);
        l_p1     = l_gnt && !a_gnt;
        l_p2     = l_gnt && a_gnt;
        // Acceptance is withheld under reset so a pending load is not lost.
        ld_ready = !reset && (l_gnt || l_squash);
    end

    always_comb begin
        we1_d = a_gnt || l_p1;
        we2_d = b_gnt || l_p2;
        wd1_d = '0;
        wd2_d = '0;
        dest1 = a_gnt ? a_dest : ld_dest;
        dest2 = b_gnt ? b_dest : ld_dest;
        if (a_gnt) begin
            wd1_d = a_data;
        end else if (l_p1) begin
            wd1_d = ld_data;
        end
        if (b_gnt) begin
            wd2_d = b_data;
        end else if (l_p2) begin
            wd2_d = ld_data;
        end
        dec_d = '0;
        sel_d = '0;
        if (we1_d) begin
            dec_d[dest1] = 1'b1;
        end
        if (we2_d) begin
            dec_d[dest2] = 1'b1;
            sel_d[dest2] = 1'b1;
        end
        squash_d = l_squash;
    end

    // Starvation tracking: stall is raised once the wait count reaches the limit.
    always_comb begin
        if (!ld_valid || ld_ready) begin
            cnt_d = '0;
        end else if (cnt_q < LIMIT) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        stall_d = (cnt_d == LIMIT);
        err_d   = err_q || (stall_q && (a_valid || b_valid));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we1_q    <= 1'b0;
            we2_q    <= 1'b0;
            wd1_q    <= '0;
            wd2_q    <= '0;
            dec_q    <= '0;
            sel_q    <= '0;
            squash_q <= 1'b0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            we1_q    <= we1_d;
            we2_q    <= we2_d;
            wd1_q    <= wd1_d;
            wd2_q    <= wd2_d;
            dec_q    <= dec_d;
            sel_q    <= sel_d;
            squash_q <= squash_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign regWrite1   = we1_q;
    assign regWrite2   = we2_q;
    assign writeData_1 = wd1_q;
    assign writeData_2 = wd2_q;
    assign dec_vec     = dec_q;
    assign sel_vec     = sel_q;
    assign ld_squash   = squash_q;
    assign stall_req   = stall_q;
    assign err         = err_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic against
// a cycle-level reference model of the arbitration rules.
module tb_wb_port_arbiter;

    localparam int NREG = 8;
    localparam int DW   = 32;
    localparam int LIM  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            a_valid, b_valid, ld_valid;
    logic [2:0]      a_dest, b_dest, ld_dest;
    logic [DW-1:0]   a_data, b_data, ld_data;
    logic            ld_ready, ld_squash, regWrite1, regWrite2, stall_req, err;
    logic [DW-1:0]   writeData_1, writeData_2;
    logic [NREG-1:0] dec_vec, sel_vec;

    always #5 clk = ~clk;

    wb_port_arbiter #(.NREG(NREG), .DW(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data),
        .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data),
        .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_squash(ld_squash),
        .regWrite1(regWrite1), .regWrite2(regWrite2),
        .writeData_1(writeData_1), .writeData_2(writeData_2),
        .dec_vec(dec_vec), .sel_vec(sel_vec),
        .stall_req(stall_req), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    bit m_stall = 0;
    int m_wait  = 0;
    bit m_err   = 0;
    bit acc     = 0;

    // One clock: check combinational ready, then the registered result.
    task automatic step();
        bit a_ok, b_ok, clash, accepted, exp_rdy, e_sq;
        int lport;
        bit            pwe [1:2];
        logic [2:0]    pdest [1:2];
        logic [DW-1:0] pdata [1:2];
        logic [NREG-1:0] edec, esel;
        #1;
        pwe[1] = 0; pwe[2] = 0;
        pdest[1] = 0; pdest[2] = 0;
        pdata[1] = 0; pdata[2] = 0;
        e_sq = 0;
        exp_rdy = 0;
        if (reset) begin
            m_stall = 0; m_wait = 0; m_err = 0;
        end else begin
            a_ok  = a_valid && !m_stall && !(b_valid && a_dest == b_dest);
            b_ok  = b_valid && !m_stall;
            clash = ld_valid && ((a_ok && ld_dest == a_dest) || (b_ok && ld_dest == b_dest));
            lport = 0;
            if (ld_valid && !clash) begin
                if (!a_ok) lport = 1;
                else if (!b_valid) lport = 2;
            end
            if (a_ok) begin pwe[1] = 1; pdest[1] = a_dest; pdata[1] = a_data; end
            if (b_ok) begin pwe[2] = 1; pdest[2] = b_dest; pdata[2] = b_data; end
            if (lport != 0) begin pwe[lport] = 1; pdest[lport] = ld_dest; pdata[lport] = ld_data; end
            accepted = ld_valid && (lport != 0 || clash);
            exp_rdy  = accepted;
            e_sq     = clash;
            m_err    = m_err || (m_stall && (a_valid || b_valid));
            if (ld_valid && !accepted) m_wait = (m_wait < LIM) ? m_wait + 1 : LIM;
            else m_wait = 0;
            m_stall = (m_wait == LIM);
        end
        edec = '0; esel = '0;
        for (int p = 1; p <= 2; p++) begin
            if (pwe[p]) begin
                edec[pdest[p]] = 1'b1;
                if (p == 2) esel[pdest[p]] = 1'b1;
            end
        end
        check_eq("ld_ready", ld_ready, exp_rdy);
        acc = exp_rdy;
        @(posedge clk);
        #1;
        check_eq("regWrite1", regWrite1, pwe[1]);
        check_eq("regWrite2", regWrite2, pwe[2]);
        check_eq("writeData_1", writeData_1, pdata[1]);
        check_eq("writeData_2", writeData_2, pdata[2]);
        check_eq("dec_vec", dec_vec, edec);
        check_eq("sel_vec", sel_vec, esel);
        check_eq("ld_squash", ld_squash, e_sq);
        check_eq("stall_req", stall_req, m_stall);
        check_eq("err", err, m_err);
    endtask

    task automatic drive(input bit av, input int ad, input logic [DW-1:0] adat,
                         input bit bv, input int bd, input logic [DW-1:0] bdat,
                         input bit lv, input int ldd, input logic [DW-1:0] ldat);
        a_valid = av;  a_dest = 3'(ad);  a_data = adat;
        b_valid = bv;  b_dest = 3'(bd);  b_data = bdat;
        ld_valid = lv; ld_dest = 3'(ldd); ld_data = ldat;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int zero_rdy;

    initial begin
        reset = 1;
        idle();
        step();
        step();
        check_eq("reset_dec", dec_vec, 0);
        check_eq("reset_stall", stall_req, 0);
        reset = 0;

        // Two independent ALU writes
        drive(1, 2, 32'h11, 1, 5, 32'h22, 0, 0, 0);
        step();
        check_eq("s1_dec", dec_vec, 8'h24);
        check_eq("s1_sel", sel_vec, 8'h20);
        check_eq("s1_wd1", writeData_1, 32'h11);
        check_eq("s1_wd2", writeData_2, 32'h22);

        // A/B same destination: B wins on port 2
        drive(1, 3, 32'hAA, 1, 3, 32'hBB, 0, 0, 0);
        step();
        check_eq("s2_we1", regWrite1, 0);
        check_eq("s2_dec", dec_vec, 8'h08);
        check_eq("s2_wd2", writeData_2, 32'hBB);

        // Load takes the idle port 1
        drive(0, 0, 0, 1, 1, 32'h55, 1, 6, 32'h99);
        step();
        check_eq("s3_rdy", acc, 1);
        check_eq("s3_dec", dec_vec, 8'h42);
        check_eq("s3_sel", sel_vec, 8'h02);
        check_eq("s3_wd1", writeData_1, 32'h99);

        // Load squashed by same-destination A write
        drive(1, 4, 32'h44, 0, 0, 0, 1, 4, 32'h77);
        step();
        check_eq("s4_squash", ld_squash, 1);
        check_eq("s4_dec", dec_vec, 8'h10);
        check_eq("s4_we2", regWrite2, 0);
        idle();
        step();
        check_eq("s4_squash_pulse", ld_squash, 0);

        // Starvation then clean stall
        zero_rdy = 0;
        for (int i = 0; i < LIM; i++) begin
            drive(1, 0, 32'hA0 + i, 1, 1, 32'hB0 + i, 1, 7, 32'hCAFE);
            step();
            if (!acc) zero_rdy++;
        end
        check_eq("s5_wait_cycles", zero_rdy, LIM);
        check_eq("s5_stall", stall_req, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 7, 32'hCAFE);
        step();
        check_eq("s5_ld_wd1", writeData_1, 32'hCAFE);
        check_eq("s5_stall_clr", stall_req, 0);
        check_eq("s5_err_clean", err, 0);

        // Starvation with A kept high during the stall
        for (int i = 0; i < LIM; i++) begin
            drive(1, 0, 32'h1, 1, 1, 32'h2, 1, 7, 32'hBEEF);
            step();
        end
        drive(1, 0, 32'h1, 0, 0, 0, 1, 7, 32'hBEEF);
        step();
        check_eq("s5_err_set", err, 1);
        idle();
        step();
        check_eq("s5_err_sticky", err, 1);

        // Reset during stall
        for (int i = 0; i < LIM; i++) begin
            drive(1, 0, 32'h1, 1, 1, 32'h2, 1, 7, 32'h3);
            step();
        end
        check_eq("s6_stall_before", stall_req, 1);
        reset = 1;
        step();
        check_eq("s6_stall", stall_req, 0);
        check_eq("s6_err", err, 0);
        check_eq("s6_dec", dec_vec, 0);
        reset = 0;
        drive(1, 2, 32'h11, 1, 5, 32'h22, 0, 0, 0);
        step();
        check_eq("s6_after_dec", dec_vec, 8'h24);

        // Randomized traffic with bursty pressure and occasional resets
        idle();
        acc = 0;
        for (int c = 0; c < 3000; c++) begin
            int pressure;
            pressure = (((c / 40) % 3) == 2) ? 9 : 5;
            if (acc) ld_valid = 0;
            reset   = ($urandom_range(0, 249) == 0);
            a_valid = ($urandom_range(0, 9) < pressure);
            b_valid = ($urandom_range(0, 9) < pressure);
            a_dest  = 3'($urandom_range(0, 7));
            b_dest  = 3'($urandom_range(0, 7));
            a_data  = $urandom;
            b_data  = $urandom;
            if (!ld_valid) begin
                if ($urandom_range(0, 2) == 0) begin
                    ld_valid = 1;
                    ld_dest  = 3'($urandom_range(0, 7));
                    ld_data  = $urandom;
                end
            end else if ($urandom_range(0, 59) == 0) begin
                ld_valid = 0;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
